// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM encodings, group geometry
// and a saturating-add helper for the optional FETCH_PERF_EN counters.
package fetch_pkg;

  localparam int FETCH_WIDTH = 4;
  localparam int INST_W      = 32;
  localparam int LINE_BYTES  = 16;

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [2:0] n);
    logic [32:0] s;
    s = {1'b0, v} + {30'd0, n};
    sat_add = s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational line shifter: drops the words before the fetch offset so that
// inst0 is the first instruction at the fetch PC; vacated slots read as zero.
module fetch_align
  import fetch_pkg::*;
#(
  parameter int LINE_W = 128
) (
  input  logic [1:0]        offset,
  input  logic [LINE_W-1:0] line,
  output logic [INST_W-1:0] inst0,
  output logic [INST_W-1:0] inst1,
  output logic [INST_W-1:0] inst2,
  output logic [INST_W-1:0] inst3,
  output logic [2:0]        count
);

  logic [LINE_W-1:0] shifted;

  // word shift by offset zero-fills the upper slots
  always_comb begin
    shifted = line >> {offset, 5'd0};
    inst0   = shifted[31:0];
    inst1   = shifted[63:32];
    inst2   = shifted[95:64];
    inst3   = shifted[127:96];
    count   = 3'd4 - {1'b0, offset};
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding 16-byte I-cache request, aligned group write to
// the instruction buffer, redirect/kill handling. Optional macro: FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                LINE_W   = 128,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ic_req_valid,
  input  logic              ic_req_ready,
  output logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_resp_valid,
  input  logic [LINE_W-1:0] ic_resp_data,
  input  logic              ibuf_full,
  output logic [INST_W-1:0] inst0,
  output logic [INST_W-1:0] inst1,
  output logic [INST_W-1:0] inst2,
  output logic [INST_W-1:0] inst3,
  output logic [2:0]        inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_groups,
  output logic [31:0]       perf_insts,
  output logic [31:0]       perf_stall_full,
  output logic [31:0]       perf_killed
`endif
);

  logic [0:0]        state;
  logic              kill;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        offset;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] next_line;
  logic              handshake;
  logic              resp_accept;
  logic [INST_W-1:0] al_inst0, al_inst1, al_inst2, al_inst3;
  logic [2:0]        al_count;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];

  fetch_align #(.LINE_W(LINE_W)) u_align (
    .offset (offset),
    .line   (ic_resp_data),
    .inst0  (al_inst0),
    .inst1  (al_inst1),
    .inst2  (al_inst2),
    .inst3  (al_inst3),
    .count  (al_count)
  );

  // request side is combinational so ibuf_full gates the request in the same cycle
  always_comb begin
    line_base    = {pc[ADDR_W-1:4], 4'b0000};
    next_line    = line_base + ADDR_W'(LINE_BYTES);
    ic_req_addr  = line_base;
    ic_req_valid = !reset && (state == S_REQ) && !ibuf_full;
    handshake    = ic_req_valid && ic_req_ready;
    resp_accept  = (state == S_WAIT) && ic_resp_valid && !kill && !redirect_valid;
  end

  // FSM, pc and one-cycle buffer write registers; redirect always beats pc+16
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      kill       <= 1'b0;
      pc         <= RESET_PC;
      offset     <= 2'd0;
      inst0      <= 32'd0;
      inst1      <= 32'd0;
      inst2      <= 32'd0;
      inst3      <= 32'd0;
      inst_valid <= 3'd0;
    end else begin
      inst0      <= 32'd0;
      inst1      <= 32'd0;
      inst2      <= 32'd0;
      inst3      <= 32'd0;
      inst_valid <= 3'd0;
      case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          if (handshake) begin
            state  <= S_WAIT;
            offset <= pc[3:2];
            kill   <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (ic_resp_valid) begin
            state <= S_REQ;
            kill  <= 1'b0;
            if (redirect_valid) begin
              pc <= redirect_pc;
            end else if (!kill) begin
              pc         <= next_line;
              inst0      <= al_inst0;
              inst1      <= al_inst1;
              inst2      <= al_inst2;
              inst3      <= al_inst3;
              inst_valid <= al_count;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_pc;
            kill <= 1'b1;
          end
        end
        default: begin
          state <= S_REQ;
          kill  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic resp_drop;
  assign resp_drop = (state == S_WAIT) && ic_resp_valid && (kill || redirect_valid);

  // saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_groups <= 32'd0;
      perf_insts        <= 32'd0;
      perf_stall_full   <= 32'd0;
      perf_killed       <= 32'd0;
    end else begin
      if (resp_accept) begin
        perf_fetch_groups <= sat_add(perf_fetch_groups, 3'd1);
        perf_insts        <= sat_add(perf_insts, al_count);
      end
      if ((state == S_REQ) && ibuf_full) begin
        perf_stall_full <= sat_add(perf_stall_full, 3'd1);
      end
      if (resp_drop) begin
        perf_killed <= sat_add(perf_killed, 3'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected request addresses and buffer
// groups are queued as stimulus is driven and popped when the DUT produces them.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] i3;
    logic [2:0]  cnt;
  } grp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'd0;
  logic         ic_req_valid;
  logic         ic_req_ready = 1'b0;
  logic [31:0]  ic_req_addr;
  logic         ic_resp_valid = 1'b0;
  logic [127:0] ic_resp_data = 128'd0;
  logic         ibuf_full = 1'b0;
  logic [31:0]  inst0, inst1, inst2, inst3;
  logic [2:0]   inst_valid;
`ifdef FETCH_PERF_EN
  logic [31:0]  perf_fetch_groups, perf_insts, perf_stall_full, perf_killed;
`endif

  int checks = 0;
  int errors = 0;
  grp_t        sb[$];
  logic [31:0] rq[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_req_valid   (ic_req_valid),
    .ic_req_ready   (ic_req_ready),
    .ic_req_addr    (ic_req_addr),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .ibuf_full      (ibuf_full),
    .inst0          (inst0),
    .inst1          (inst1),
    .inst2          (inst2),
    .inst3          (inst3),
    .inst_valid     (inst_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_groups (perf_fetch_groups),
    .perf_insts        (perf_insts),
    .perf_stall_full   (perf_stall_full),
    .perf_killed       (perf_killed)
`endif
  );

  // reference alignment: word (off+i) of the line lands in slot i
  function automatic grp_t align_model(input logic [127:0] line, input int off);
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = off + i;
      if (idx < 4) w[i] = line[32*idx +: 32];
      else         w[i] = 32'd0;
    end
    align_model = '{w[0], w[1], w[2], w[3], 3'(4 - off)};
  endfunction

  // scoreboard consumer: buffer writes and request handshakes
  always @(negedge clk) begin
    if (!reset && inst_valid != 3'd0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write inst_valid=%0d required no write", inst_valid);
      end else begin
        grp_t e;
        e = sb.pop_front();
        if ({inst0, inst1, inst2, inst3, inst_valid} !== e) begin
          errors++;
          $display("FAIL group got %h %h %h %h n=%0d required %h %h %h %h n=%0d",
                   inst0, inst1, inst2, inst3, inst_valid, e.i0, e.i1, e.i2, e.i3, e.cnt);
        end
      end
    end
    if (!reset && ic_req_valid && ic_req_ready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req addr=%h required no request", ic_req_addr);
      end else begin
        logic [31:0] a;
        a = rq.pop_front();
        if (ic_req_addr !== a) begin
          errors++;
          $display("FAIL req_addr got %h required %h", ic_req_addr, a);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req();
    bit got;
    got = 1'b0;
    ic_req_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (ic_req_valid === 1'b1) got = 1'b1;
      tick();
    end
    ic_req_ready = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout got no ic_req_valid required one within 20 cycles");
    end
  endtask

  task automatic send_resp(input logic [127:0] line);
    ic_resp_data  = line;
    ic_resp_valid = 1'b1;
    tick();
    ic_resp_valid = 1'b0;
  endtask

  task automatic fetch_line(input logic [31:0] addr, input logic [127:0] line,
                            input grp_t exp, input bit write);
    rq.push_back(addr);
    accept_req();
    if (write) sb.push_back(exp);
    send_resp(line);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ic_req_valid !== 1'b0 || inst_valid !== 3'd0 || inst0 !== 32'd0 || inst3 !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs got req=%b n=%0d i0=%h i3=%h required 0",
                 ic_req_valid, inst_valid, inst0, inst3);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL first_req got valid=%b addr=%h required 1 00001000", ic_req_valid, ic_req_addr);
    end
  endtask

  task automatic test_aligned();
    rq.push_back(32'h0000_1000);
    accept_req();
    #1;
    checks++;
    if (ic_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_no_req got %b required 0", ic_req_valid);
    end
    sb.push_back('{32'h0, 32'h1, 32'h2, 32'h3, 3'd4});
    send_resp({32'h3, 32'h2, 32'h1, 32'h0});
    fetch_line(32'h0000_1010, 128'hAAAA_0003_AAAA_0002_AAAA_0001_AAAA_0000,
               '{32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 3'd4}, 1'b1);
  endtask

  task automatic test_redirect_offset();
    redirect_pc    = 32'h0000_2008;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    fetch_line(32'h0000_2000, {32'hD3, 32'hD2, 32'hD1, 32'hD0},
               '{32'hD2, 32'hD3, 32'h0, 32'h0, 3'd2}, 1'b1);
    fetch_line(32'h0000_2010, {32'hE3, 32'hE2, 32'hE1, 32'hE0},
               align_model({32'hE3, 32'hE2, 32'hE1, 32'hE0}, 0), 1'b1);
  endtask

  task automatic test_full();
    logic [127:0] line;
    ibuf_full = 1'b1;
    ic_req_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (ic_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL full_gate cycle %0d got %b required 0", c, ic_req_valid);
      end
      tick();
    end
    ic_req_ready = 1'b0;
    ibuf_full = 1'b0;
    #1;
    checks++;
    if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0000_2020) begin
      errors++;
      $display("FAIL full_resume got valid=%b addr=%h required 1 00002020", ic_req_valid, ic_req_addr);
    end
    line = {$urandom, $urandom, $urandom, $urandom};
    fetch_line(32'h0000_2020, line, align_model(line, 0), 1'b1);
    // full raised while the response is in flight: still written
    rq.push_back(32'h0000_2030);
    accept_req();
    ibuf_full = 1'b1;
    line = {$urandom, $urandom, $urandom, $urandom};
    sb.push_back(align_model(line, 0));
    send_resp(line);
    #1;
    checks++;
    if (ic_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_after_resp got %b required 0", ic_req_valid);
    end
    ibuf_full = 1'b0;
  endtask

  task automatic test_kill();
    logic [127:0] line;
    rq.push_back(32'h0000_2040);
    accept_req();
    redirect_pc    = 32'h0000_3000;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    tick();
    send_resp({$urandom, $urandom, $urandom, $urandom});
    #1;
    checks++;
    if (inst_valid !== 3'd0) begin
      errors++;
      $display("FAIL late_resp_dropped got n=%0d required 0", inst_valid);
    end
    line = {$urandom, $urandom, $urandom, $urandom};
    fetch_line(32'h0000_3000, line, align_model(line, 0), 1'b1);
    // redirect coincident with the handshake kills that request
    redirect_pc    = 32'h0000_3100;
    redirect_valid = 1'b1;
    rq.push_back(32'h0000_3010);
    accept_req();
    redirect_valid = 1'b0;
    send_resp({$urandom, $urandom, $urandom, $urandom});
    line = {$urandom, $urandom, $urandom, $urandom};
    fetch_line(32'h0000_3100, line, align_model(line, 0), 1'b1);
  endtask

  task automatic test_same_cycle_wrap();
    logic [127:0] line;
    rq.push_back(32'h0000_3110);
    accept_req();
    redirect_pc    = 32'hFFFF_FFF4;
    redirect_valid = 1'b1;
    send_resp({$urandom, $urandom, $urandom, $urandom});
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 3'd0) begin
      errors++;
      $display("FAIL same_cycle_no_write got n=%0d required 0", inst_valid);
    end
    fetch_line(32'hFFFF_FFF0, {32'hF3, 32'hF2, 32'hF1, 32'hF0},
               '{32'hF1, 32'hF2, 32'hF3, 32'h0, 3'd3}, 1'b1);
    line = {$urandom, $urandom, $urandom, $urandom};
    fetch_line(32'h0000_0000, line, align_model(line, 0), 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [127:0] line;
    for (int k = 0; k < 4; k++) begin
      line = {$urandom, $urandom, $urandom, $urandom};
      fetch_line(32'h10 * (k + 1), line, align_model(line, 0), 1'b1);
    end
    repeat (3) tick();
    checks++;
    if (sb.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drained got sb=%0d rq=%0d required 0 0", sb.size(), rq.size());
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_redirect_offset();
    test_full();
    test_kill();
    test_same_cycle_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
